vga_pixel_sink: RTL
===================

# vga_pixel_sink

Display back-end for the chromatic adaptation pipeline on the DE2-115. It accepts adapted 24-bit RGB pixels from the adaptation core over a valid/ready stream and buffers them in a small FIFO. It generates 640x480@60 Hz VGA timing from CLOCK_50 and drives the on-board ADV7123 DAC pins. It replaces the static tie-offs currently on the VGA outputs.

## Interface
Parameters:
- FIFO_DEPTH, 16: pixel FIFO depth in words; power of two, 4..256.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  FIFO not full.
- VGA_R / VGA_G / VGA_B  out  8 each  DAC colour.
- VGA_CLK  out  1  25 MHz pixel clock.
- VGA_BLANK_N  out  1  high in active video.
- VGA_SYNC_N  out  1  constant 0.
- VGA_HS / VGA_VS  out  1 each  sync, active-low.
- underrun  out  1  sticky; active pixel found FIFO empty.
- frame_start  out  1  one-cycle pulse at pixel (0,0).

## Operation
- Pixel enable `pe` toggles every CLOCK_50 cycle; reset value 0. VGA_CLK is a register that toggles with `pe` and is high on the cycles where `pe`=1.
- Counters: h_cnt 0..799 and v_cnt 0..524. Both advance only when `pe`=1. h_cnt wraps from 799 to 0 and increments v_cnt at the same time. v_cnt wraps from 524 to 0.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- active = (h_cnt<640) && (v_cnt<480).
- FIFO write:
  - Occurs when pix_valid && pix_ready.
  - pix_ready = (count != FIFO_DEPTH).
- FIFO read:
  - Pops the head when pe && active && count!=0.
  - A write and a read in the same cycle both take effect; count is unchanged.
  - No read occurs when count=0, even if a write lands that cycle.
- Count width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Output registers update only on cycles with pe=1:
  - Active pixel, FIFO non-empty: RGB = FIFO head.
  - Active pixel, FIFO empty: RGB = underrun colour and underrun <= 1.
  - Blanking: RGB = 0.
  - VGA_BLANK_N = active; VGA_HS / VGA_VS per the sync ranges.
- underrun clears only on reset.
- frame_start = pe && h_cnt==0 && v_cnt==0.
- Pixels are never dropped or reordered. No frame resynchronisation: the upstream stage supplies exactly 640x480 pixels per frame, in order.

## Timing
- Reset values:
  - pe 0, VGA_CLK 0, h_cnt 0, v_cnt 0, count 0.
  - VGA_R/G/B 0, VGA_BLANK_N 0, VGA_HS 1, VGA_VS 1, VGA_SYNC_N 0.
  - underrun 0, frame_start 0. pix_ready is 1 while count=0.
- Reset is asynchronous: asserting it mid-line or mid-frame forces all reset values immediately and discards FIFO contents.
- Output latency is one pixel: outputs reflect the counter state sampled on the previous pe=1 cycle, i.e. 2 CLOCK_50 cycles behind the counters.
- Write-to-ready: pix_ready falls in the cycle after the write that fills the FIFO. It rises in the cycle after the first pop from full.
- Periods: line = 1600 CLOCK_50 cycles; frame = 840000 CLOCK_50 cycles.

## Configuration
- VGA_COLOR_BARS_EN defined: the underrun colour is a bar pattern.
  - R = h_cnt[8] ? FF : 00; G = h_cnt[7] ? FF : 00; B = h_cnt[6] ? FF : 00.
- Not defined: the underrun colour is 000000.
- underrun flag behaviour is identical in both builds.

## Test plan
- Reset then release, pix_valid=0: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=000000, VGA_SYNC_N=0, pix_ready=1.
- Free run for 2 frames:
  - VGA_HS low for 192 cycles every 1600 cycles.
  - VGA_VS low for 3200 cycles every 840000 cycles.
  - frame_start pulses once per 840000 cycles.
  - VGA_BLANK_N high for 1280 cycles per active line.
- During vertical blanking (v_cnt=500), drive pix_valid=1 continuously: exactly FIFO_DEPTH=16 words accepted, then pix_ready=0 until the first active pixel pops.
- Stream FF0000 with pix_valid held 1 from reset: every active pixel outputs FF0000, underrun stays 0 over a full frame.
- No input with VGA_COLOR_BARS_EN defined:
  - Pixels h=0..63 give 000000 and h=64..127 give 0000FF.
  - underrun=1 from the first active pixel output onward.
  - Without the macro, all active pixels are 000000.
- Pull rst_n low at h_cnt=300, v_cnt=100 with the FIFO holding 8 words: outputs immediately take reset values; after release count=0 and h_cnt/v_cnt restart at 0.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// 640x480@60 VGA back-end: pixel FIFO, timing generator and ADV7123 drive.
// Define VGA_COLOR_BARS_EN to show colour bars instead of black on underrun.
module vga_pixel_sink #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        underrun,
    output logic        frame_start
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          pe_q, pe_d;
    logic          vga_clk_q, vga_clk_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          blank_n_q, blank_n_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          underrun_q, underrun_d;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [23:0]   head;
    logic [23:0]   und_rgb;
    logic          active;
    logic          wr_en;
    logic          rd_en;
    logic          empty;

    always_comb begin
        active    = (h_cnt_q < 10'd640) && (v_cnt_q < 10'd480);
        empty     = (count_q == '0);
        pix_ready = (count_q != CW'(FIFO_DEPTH));
        wr_en     = pix_valid && pix_ready;
        rd_en     = pe_q && active && !empty;
        head      = mem[rd_ptr_q];
`ifdef VGA_COLOR_BARS_EN
        und_rgb   = {{8{h_cnt_q[8]}}, {8{h_cnt_q[7]}}, {8{h_cnt_q[6]}}};
`else
        und_rgb   = 24'h000000;
`endif
    end

    always_comb begin
        pe_d       = ~pe_q;
        vga_clk_d  = ~pe_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rgb_d      = rgb_q;
        blank_n_d  = blank_n_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        underrun_d = underrun_q;

        if (pe_q) begin
            if (h_cnt_q == 10'd799) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == 10'd524) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end

            // Outputs carry the state of the pixel just sampled.
            if (active && !empty) begin
                rgb_d = head;
            end else if (active) begin
                rgb_d      = und_rgb;
                underrun_d = 1'b1;
            end else begin
                rgb_d = 24'h000000;
            end
            blank_n_d = active;
            hs_d = !((h_cnt_q >= 10'd656) && (h_cnt_q <= 10'd751));
            vs_d = !((v_cnt_q >= 10'd490) && (v_cnt_q <= 10'd491));
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pe_q       <= 1'b0;
            vga_clk_q  <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rgb_q      <= '0;
            blank_n_q  <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            pe_q       <= pe_d;
            vga_clk_q  <= vga_clk_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rgb_q      <= rgb_d;
            blank_n_q  <= blank_n_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= pix_data;
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_CLK     = vga_clk_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign underrun    = underrun_q;
    assign frame_start = pe_q && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule
